// File: rtl/lock_controller_v2.sv
// lock_controller_v2: keypad lock controller.
// Collects digits from the keypad encoder, lets the user set a passcode
// (enter, then confirm) while unlocked, then locks. A matching entry unlocks;
// MAX_ATTEMPTS consecutive wrong codes start a timed lockout.
module lock_controller_v2 #(
  parameter int CLOCK_FREQ      = 50000000,
  parameter int TIMEOUT_CYCLES  = 10 * CLOCK_FREQ,
  parameter int LOCKOUT_CYCLES  = 30 * CLOCK_FREQ,
  parameter int DIGIT_WIDTH     = 4,
  parameter int PASSCODE_LENGTH = 4,
  parameter int CODE_WIDTH      = DIGIT_WIDTH * PASSCODE_LENGTH,
  parameter logic [CODE_WIDTH-1:0] DEFAULT_PASSCODE = 16'h8148,
  parameter int MAX_ATTEMPTS    = 3
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [DIGIT_WIDTH-1:0]               key,
  output logic                                 locked,
  output logic                                 error,
  output logic                                 lockout,
  output logic [CODE_WIDTH-1:0]                userEntry,
  output logic [$clog2(PASSCODE_LENGTH+1)-1:0] entry_count,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]    attempts_left
);

  localparam int CNT_W     = $clog2(PASSCODE_LENGTH + 1);
  localparam int ATT_W     = $clog2(MAX_ATTEMPTS + 1);
  localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LOCKOUT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [2:0] {
    SET1       = 3'd0,
    SET2       = 3'd1,
    CMP_SET    = 3'd2,
    LOCKED     = 3'd3,
    CMP_UNLOCK = 3'd4,
    LOCKOUT    = 3'd5
  } state_t;

  state_t                 state;
  logic                   armed;
  logic [CODE_WIDTH-1:0]  passcode;
  logic [CODE_WIDTH-1:0]  candidate;
  logic [TIMEOUT_W-1:0]   timeout_cnt;
  logic [LOCKOUT_W-1:0]   lockout_cnt;

  logic in_entry;
  logic accept;
  logic entry_full;
  logic timer_run;
  logic timeout_hit;

  // Decode press acceptance, a complete entry and the inter-digit timeout.
  // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
  always_comb begin
    in_entry    = (state == SET1) || (state == SET2) || (state == LOCKED);
    accept      = in_entry && armed && (key != '0);
    entry_full  = (entry_count == CNT_W'(PASSCODE_LENGTH));
    timer_run   = in_entry && (entry_count != '0) && !entry_full;
    timeout_hit = timer_run && (timeout_cnt == TIMEOUT_W'(TIMEOUT_CYCLES));
  end

  // Main controller: entry shift register, timers, state and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: passcode and candidate are plain registers, not RAM, so they take
      // a reset value; the lock must come up with a known code.
      state         <= SET1;
      armed         <= 1'b0;
      locked        <= 1'b0;
      error         <= 1'b0;
      lockout       <= 1'b0;
      userEntry     <= '0;
      entry_count   <= '0;
      attempts_left <= ATT_W'(MAX_ATTEMPTS);
      passcode      <= DEFAULT_PASSCODE;
      candidate     <= '0;
      timeout_cnt   <= '0;
      lockout_cnt   <= '0;
    end else begin
      // Only a release-then-press edge arms acceptance; held keys never repeat.
      armed <= (key == '0);

      case (state)
        SET1, SET2, LOCKED: begin
          if (entry_full) begin
            // A full entry is consumed on the edge after its last digit.
            if (state == SET1) begin
              candidate   <= userEntry;
              userEntry   <= '0;
              entry_count <= '0;
              timeout_cnt <= '0;
              state       <= SET2;
            end else if (state == SET2) begin
              state <= CMP_SET;
            end else begin
              state <= CMP_UNLOCK;
            end
          end else if (accept) begin
            // An accepted press beats a timeout landing on the same edge.
            userEntry   <= CODE_WIDTH'({userEntry, key});
            entry_count <= entry_count + CNT_W'(1);
            error       <= 1'b0;
            timeout_cnt <= '0;
          end else if (timeout_hit) begin
            error       <= 1'b1;
            userEntry   <= '0;
            entry_count <= '0;
            timeout_cnt <= '0;
            if (state == SET2) state <= SET1;
          end else if (timer_run) begin
            timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
          end else begin
            timeout_cnt <= '0;
          end
        end

        CMP_SET: begin
          userEntry   <= '0;
          entry_count <= '0;
          timeout_cnt <= '0;
          if (userEntry == candidate) begin
            passcode <= candidate;
            locked   <= 1'b1;
            state    <= LOCKED;
          end else begin
            error <= 1'b1;
            state <= SET1;
          end
        end

        CMP_UNLOCK: begin
          userEntry   <= '0;
          entry_count <= '0;
          timeout_cnt <= '0;
          if (userEntry == passcode) begin
            locked        <= 1'b0;
            attempts_left <= ATT_W'(MAX_ATTEMPTS);
            state         <= SET1;
          end else begin
            error         <= 1'b1;
            attempts_left <= attempts_left - ATT_W'(1);
            if (attempts_left <= ATT_W'(1)) begin
              lockout     <= 1'b1;
              lockout_cnt <= '0;
              state       <= LOCKOUT;
            end else begin
              state <= LOCKED;
            end
          end
        end

        LOCKOUT: begin
          // Keys are ignored; error stays set until the next accepted press.
          if (lockout_cnt == LOCKOUT_W'(LOCKOUT_CYCLES - 1)) begin
            lockout       <= 1'b0;
            attempts_left <= ATT_W'(MAX_ATTEMPTS);
            state         <= LOCKED;
          end else begin
            lockout_cnt <= lockout_cnt + LOCKOUT_W'(1);
          end
        end

        default: begin
          // Corrupted state register: restart entry, keep lock and passcode.
          userEntry   <= '0;
          entry_count <= '0;
          timeout_cnt <= '0;
          state       <= SET1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lock_controller_v2.sv
// Directed testbench for lock_controller_v2 with short timeouts.
module tb_lock_controller_v2;

  logic        clock;
  logic        reset;
  logic [3:0]  key;
  logic        locked;
  logic        error;
  logic        lockout;
  logic [15:0] userEntry;
  logic [2:0]  entry_count;
  logic [1:0]  attempts_left;

  int checks = 0;
  int passed = 0;

  lock_controller_v2 #(
    .CLOCK_FREQ      (1000),
    .TIMEOUT_CYCLES  (20),
    .LOCKOUT_CYCLES  (50),
    .DIGIT_WIDTH     (4),
    .PASSCODE_LENGTH (4),
    .DEFAULT_PASSCODE(16'h8148),
    .MAX_ATTEMPTS    (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .key          (key),
    .locked       (locked),
    .error        (error),
    .lockout      (lockout),
    .userEntry    (userEntry),
    .entry_count  (entry_count),
    .attempts_left(attempts_left)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n rising edges, landing 1 ns after the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One keypress: accepted on the first edge, released on the second.
  task automatic press(input logic [3:0] d);
    key = d;
    step(1);
    key = 4'h0;
    step(1);
  endtask

  task automatic enter_code(input logic [15:0] code);
    logic [15:0] c;
    c = code;
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key   = 4'h0;
    step(2);
    reset = 1'b0;
    step(1);
  endtask

  // Set and confirm 1234; ends 2 edges after the last accept (locked=1).
  task automatic lock_with_1234();
    enter_code(16'h1234);
    enter_code(16'h1234);
    step(1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0h want 0", locked); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL reset_error: got %0h want 0", error); else passed++;
    checks++; if (lockout !== 1'b0) $display("FAIL reset_lockout: got %0h want 0", lockout); else passed++;
    checks++; if (userEntry !== 16'h0000) $display("FAIL reset_entry: got %h want 0000", userEntry); else passed++;
    checks++; if (entry_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", entry_count); else passed++;
    checks++; if (attempts_left !== 2'd3) $display("FAIL reset_attempts: got %0d want 3", attempts_left); else passed++;
    checks++; if (dut.passcode !== 16'h8148) $display("FAIL reset_passcode: got %h want 8148", dut.passcode); else passed++;
  endtask

  task automatic test_set_code();
    do_reset();
    enter_code(16'h1234);
    checks++; if (entry_count !== 3'd0) $display("FAIL set_first_cleared: got %0d want 0", entry_count); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL set_first_locked: got %0h want 0", locked); else passed++;
    press(4'h1); press(4'h2); press(4'h3);
    checks++; if (userEntry !== 16'h0123) $display("FAIL set_partial_entry: got %h want 0123", userEntry); else passed++;
    checks++; if (entry_count !== 3'd3) $display("FAIL set_partial_count: got %0d want 3", entry_count); else passed++;
    key = 4'h4;
    step(1);
    checks++; if (userEntry !== 16'h1234) $display("FAIL set_full_entry: got %h want 1234", userEntry); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL set_latency_e0: got %0h want 0", locked); else passed++;
    key = 4'h0;
    step(1);
    checks++; if (locked !== 1'b0) $display("FAIL set_latency_e1: got %0h want 0", locked); else passed++;
    step(1);
    checks++; if (locked !== 1'b1) $display("FAIL set_latency_e2: got %0h want 1", locked); else passed++;
    checks++; if (userEntry !== 16'h0000) $display("FAIL set_entry_cleared: got %h want 0000", userEntry); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL set_error: got %0h want 0", error); else passed++;
    checks++; if (dut.passcode !== 16'h1234) $display("FAIL set_passcode: got %h want 1234", dut.passcode); else passed++;
  endtask

  task automatic test_confirm_mismatch();
    do_reset();
    enter_code(16'h1234);
    enter_code(16'h1235);
    step(1);
    checks++; if (error !== 1'b1) $display("FAIL mismatch_error: got %0h want 1", error); else passed++;
    checks++; if (locked !== 1'b0) $display("FAIL mismatch_locked: got %0h want 0", locked); else passed++;
    checks++; if (dut.passcode !== 16'h8148) $display("FAIL mismatch_passcode: got %h want 8148", dut.passcode); else passed++;
    // Back in SET1: the first 8148 is only a candidate, the second confirms it.
    enter_code(16'h8148);
    step(1);
    checks++; if (locked !== 1'b0) $display("FAIL mismatch_resume_set1: got %0h want 0", locked); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL mismatch_error_cleared: got %0h want 0", error); else passed++;
    enter_code(16'h8148);
    step(1);
    checks++; if (locked !== 1'b1) $display("FAIL mismatch_relock: got %0h want 1", locked); else passed++;
  endtask

  task automatic test_unlock_failures();
    do_reset();
    lock_with_1234();
    for (int i = 1; i <= 3; i++) begin
      enter_code(16'h9999);
      step(1);
      checks++; if (attempts_left !== 2'(3 - i)) $display("FAIL fail%0d_attempts: got %0d want %0d", i, attempts_left, 3 - i); else passed++;
      checks++; if (error !== 1'b1) $display("FAIL fail%0d_error: got %0h want 1", i, error); else passed++;
      checks++; if (lockout !== (i == 3)) $display("FAIL fail%0d_lockout: got %0h want %0h", i, lockout, (i == 3)); else passed++;
      checks++; if (locked !== 1'b1) $display("FAIL fail%0d_locked: got %0h want 1", i, locked); else passed++;
    end
    // Lockout began on the edge just passed (L0); presses are ignored.
    press(4'h5);
    press(4'h6);
    checks++; if (userEntry !== 16'h0000) $display("FAIL lockout_ignores_keys: got %h want 0000", userEntry); else passed++;
    checks++; if (entry_count !== 3'd0) $display("FAIL lockout_count: got %0d want 0", entry_count); else passed++;
    step(45);
    checks++; if (lockout !== 1'b1) $display("FAIL lockout_edge49: got %0h want 1", lockout); else passed++;
    step(1);
    checks++; if (lockout !== 1'b0) $display("FAIL lockout_edge50: got %0h want 0", lockout); else passed++;
    checks++; if (attempts_left !== 2'd3) $display("FAIL lockout_attempts_restored: got %0d want 3", attempts_left); else passed++;
    checks++; if (error !== 1'b1) $display("FAIL lockout_error_kept: got %0h want 1", error); else passed++;
    enter_code(16'h1234);
    step(1);
    checks++; if (locked !== 1'b0) $display("FAIL unlock_after_lockout: got %0h want 0", locked); else passed++;
    checks++; if (error !== 1'b0) $display("FAIL unlock_error: got %0h want 0", error); else passed++;
  endtask

  task automatic test_held_timeout();
    do_reset();
    key = 4'h7;
    step(10);
    checks++; if (entry_count !== 3'd1) $display("FAIL held_count: got %0d want 1", entry_count); else passed++;
    checks++; if (userEntry !== 16'h0007) $display("FAIL held_entry: got %h want 0007", userEntry); else passed++;
    key = 4'h0;
    step(11);
    checks++; if (error !== 1'b0) $display("FAIL timeout_early: got %0h want 0", error); else passed++;
    step(1);
    checks++; if (error !== 1'b1) $display("FAIL timeout_error: got %0h want 1", error); else passed++;
    checks++; if (entry_count !== 3'd0) $display("FAIL timeout_count: got %0d want 0", entry_count); else passed++;
    press(4'h3);
    checks++; if (error !== 1'b0) $display("FAIL press_clears_error: got %0h want 0", error); else passed++;
    checks++; if (entry_count !== 3'd1) $display("FAIL press_after_timeout: got %0d want 1", entry_count); else passed++;
  endtask

  task automatic test_simultaneous();
    // Continues from test_held_timeout: last accept was 1 edge ago, so the
    // timeout edge is 20 edges from here; present a fresh press exactly there.
    step(19);
    key = 4'h5;
    step(1);
    checks++; if (error !== 1'b0) $display("FAIL simul_error: got %0h want 0", error); else passed++;
    checks++; if (entry_count !== 3'd2) $display("FAIL simul_count: got %0d want 2", entry_count); else passed++;
    checks++; if (userEntry !== 16'h0035) $display("FAIL simul_entry: got %h want 0035", userEntry); else passed++;
    key = 4'h0;
    step(1);
  endtask

  task automatic test_async_reset();
    do_reset();
    lock_with_1234();
    enter_code(16'h9999);
    step(1);
    press(4'h1);
    press(4'h2);
    checks++; if (entry_count !== 3'd2) $display("FAIL pre_reset_count: got %0d want 2", entry_count); else passed++;
    checks++; if (attempts_left !== 2'd2) $display("FAIL pre_reset_attempts: got %0d want 2", attempts_left); else passed++;
    #2;
    reset = 1'b1;
    key   = 4'h9;
    #1;
    checks++; if (locked !== 1'b0) $display("FAIL async_locked: got %0h want 0", locked); else passed++;
    checks++; if (userEntry !== 16'h0000) $display("FAIL async_entry: got %h want 0000", userEntry); else passed++;
    checks++; if (attempts_left !== 2'd3) $display("FAIL async_attempts: got %0d want 3", attempts_left); else passed++;
    checks++; if (dut.passcode !== 16'h8148) $display("FAIL async_passcode: got %h want 8148", dut.passcode); else passed++;
    step(2);
    reset = 1'b0;
    step(3);
    checks++; if (entry_count !== 3'd0) $display("FAIL held_through_reset: got %0d want 0", entry_count); else passed++;
    key = 4'h0;
    step(1);
    key = 4'h9;
    step(1);
    checks++; if (entry_count !== 3'd1) $display("FAIL rearm_count: got %0d want 1", entry_count); else passed++;
    checks++; if (userEntry !== 16'h0009) $display("FAIL rearm_entry: got %h want 0009", userEntry); else passed++;
    key = 4'h0;
    step(1);
  endtask

  initial begin
    reset = 1'b1;
    key   = 4'h0;
    test_reset();
    test_set_code();
    test_confirm_mismatch();
    test_unlock_failures();
    test_held_timeout();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
